// File: rtl/verilab_chip_gpio_arb.sv
// Round-robin GPIO pad-bank ownership arbiter with req/gnt/rel handshake,
// one-cycle bus turnaround, hold-time watchdog and a two-flop input synchroniser.
package proj_param_pkg;
  localparam int PROJ_GPIO = 32;
endpackage

module verilab_chip_gpio_arb #(
  parameter int GPIO     = proj_param_pkg::PROJ_GPIO,
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          rel,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner_id,
  input  logic [NREQ*GPIO-1:0]     req_out,
  input  logic [NREQ*GPIO-1:0]     req_oe,
  output logic [GPIO-1:0]          gpio_o,
  output logic [GPIO-1:0]          gpio_oe_o,
  input  logic [GPIO-1:0]          gpio_i,
  output logic [GPIO-1:0]          gpio_sync_o,
  output logic                     timeout_o
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t          r_state, w_state_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic [OW-1:0]   r_owner, w_owner_next;
  logic [HW-1:0]   r_hold, w_hold_next;
  logic            r_timeout, w_timeout_next;
  logic [GPIO-1:0] r_gpio, r_oe, w_gpio_next, w_oe_next;
  logic [GPIO-1:0] r_sync1, r_sync2;

  logic            w_found;
  logic [OW-1:0]   w_winner;
  logic [OW:0]     w_sum;
  logic [OW-1:0]   w_cand;
  logic            w_release;
  logic            w_expire;

  // Round-robin search starting just after the last owner, wrapping at NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_owner;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = {1'b0, r_owner} + (OW+1)'(i);
      if (w_sum >= (OW+1)'(NREQ))
        w_sum = w_sum - (OW+1)'(NREQ);
      w_cand = w_sum[OW-1:0];
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_release = rel[r_owner] | ~req[r_owner];
  assign w_expire  = (HOLD_MAX != 0) && (r_hold == HW'(HOLD_MAX - 1));

  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = r_gnt;
    w_owner_next   = r_owner;
    w_hold_next    = r_hold;
    w_timeout_next = 1'b0;
    w_gpio_next    = '0;
    w_oe_next      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_GRANT;
          w_gnt_next   = NREQ'(1) << w_winner;
          w_owner_next = w_winner;
          w_hold_next  = '0;
        end
      end
      S_GRANT: begin
        w_gpio_next = req_out[r_owner*GPIO +: GPIO];
        w_oe_next   = req_oe[r_owner*GPIO +: GPIO];
        if (r_hold != HW'(HOLD_MAX))
          w_hold_next = r_hold + HW'(1);
        // A genuine release wins over a coincident watchdog expiry.
        if (w_release || w_expire) begin
          w_state_next   = S_TURN;
          w_gnt_next     = '0;
          w_timeout_next = ~w_release;
        end
      end
      S_TURN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= OW'(NREQ - 1);
      r_hold    <= '0;
      r_timeout <= 1'b0;
      r_gpio    <= '0;
      r_oe      <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gnt     <= w_gnt_next;
      r_owner   <= w_owner_next;
      r_hold    <= w_hold_next;
      r_timeout <= w_timeout_next;
      r_gpio    <= w_gpio_next;
      r_oe      <= w_oe_next;
      r_sync1   <= gpio_i;
      r_sync2   <= r_sync1;
    end
  end

  assign gnt         = r_gnt;
  assign owner_id    = r_owner;
  assign gpio_o      = r_gpio;
  assign gpio_oe_o   = r_oe;
  assign gpio_sync_o = r_sync2;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_verilab_chip_gpio_arb.sv
// Directed self-checking bench for verilab_chip_gpio_arb (GPIO=32, NREQ=4, HOLD_MAX=8).
module tb_verilab_chip_gpio_arb;

  localparam int GPIO = 32;
  localparam int NREQ = 4;
  localparam int HOLD_MAX = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      rel = '0;
  logic [NREQ-1:0]      gnt;
  logic [1:0]           owner_id;
  logic [NREQ*GPIO-1:0] req_out = '0;
  logic [NREQ*GPIO-1:0] req_oe = '0;
  logic [GPIO-1:0]      gpio_o;
  logic [GPIO-1:0]      gpio_oe_o;
  logic [GPIO-1:0]      gpio_i = '0;
  logic [GPIO-1:0]      gpio_sync_o;
  logic                 timeout_o;

  int checks = 0;
  int failures = 0;

  verilab_chip_gpio_arb #(.GPIO(GPIO), .NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(gnt), .owner_id(owner_id),
    .req_out(req_out), .req_oe(req_oe), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o),
    .gpio_i(gpio_i), .gpio_sync_o(gpio_sync_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; rel = '0; gpio_i = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0000 || gpio_o !== '0 || gpio_oe_o !== '0 || timeout_o !== 1'b0 || gpio_sync_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b gpio_o=%h oe=%h to=%b sync=%h required all 0", gnt, gpio_o, gpio_oe_o, timeout_o, gpio_sync_o);
    end
    checks++;
    if (owner_id !== 2'd3) begin
      failures++;
      $display("FAIL reset_owner owner_id=%0d required 3", owner_id);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    req_out = '0;
    req_out[2*GPIO +: GPIO] = 32'hA5A5_0001;
    req_oe = '1;
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100 || owner_id !== 2'd2) begin
      failures++;
      $display("FAIL single_grant gnt=%b owner=%0d required 0100 owner 2", gnt, owner_id);
    end
    checks++;
    if (gpio_oe_o !== '0) begin
      failures++;
      $display("FAIL single_pad_lag oe=%h required 0", gpio_oe_o);
    end
    step();
    checks++;
    if (gpio_o !== 32'hA5A5_0001 || gpio_oe_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL single_pads gpio_o=%h oe=%h required a5a50001 ffffffff", gpio_o, gpio_oe_o);
    end
    req = '0;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_release gnt=%b required 0000", gnt);
    end
    step();
    checks++;
    if (gpio_oe_o !== '0 || gpio_o !== '0) begin
      failures++;
      $display("FAIL single_pads_off gpio_o=%h oe=%h required 0", gpio_o, gpio_oe_o);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_gnt;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      req_out[k*GPIO +: GPIO] = 32'h1000_0000 + k;
      req_oe[k*GPIO +: GPIO]  = 32'h0000_0011 << k;
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      exp_gnt = 4'b0001 << order[n];
      checks++;
      if (gnt !== exp_gnt || owner_id !== 2'(order[n])) begin
        failures++;
        $display("FAIL rr_grant[%0d] gnt=%b owner=%0d required %b owner %0d", n, gnt, owner_id, exp_gnt, order[n]);
      end
      rel = exp_gnt;
      step();
      rel = '0;
      checks++;
      if (gnt !== 4'b0000 || timeout_o !== 1'b0 || gpio_oe_o !== (32'h0000_0011 << order[n])) begin
        failures++;
        $display("FAIL rr_turn[%0d] gnt=%b to=%b oe=%h required 0000 0 %h", n, gnt, timeout_o, gpio_oe_o, 32'h0000_0011 << order[n]);
      end
      step();
      checks++;
      if (gnt !== 4'b0000 || gpio_oe_o !== '0) begin
        failures++;
        $display("FAIL rr_gap[%0d] gnt=%b oe=%h required 0000 0", n, gnt, gpio_oe_o);
      end
      $display("rr handoff %0d owner %0d", n, order[n]);
    end
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= HOLD_MAX; k++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || timeout_o !== 1'b0) begin
        failures++;
        $display("FAIL wd_hold[%0d] gnt=%b to=%b required 0010 0", k, gnt, timeout_o);
      end
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL wd_expire gnt=%b to=%b required 0000 1", gnt, timeout_o);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL wd_idle gnt=%b to=%b required 0000 0", gnt, timeout_o);
    end
    step();
    checks++;
    if (gnt !== 4'b0010 || owner_id !== 2'd1) begin
      failures++;
      $display("FAIL wd_regrant gnt=%b owner=%0d required 0010 1", gnt, owner_id);
    end
    req = '0;
    step(); step(); step();
    $display("test_watchdog done");
  endtask

  task automatic test_simul_release();
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= HOLD_MAX; k++) step();
    rel = 4'b0010;
    step();
    rel = '0;
    req = '0;
    checks++;
    if (gnt !== 4'b0000 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_release gnt=%b to=%b required 0000 0", gnt, timeout_o);
    end
    step();
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL simul_no_pulse to=%b required 0", timeout_o);
    end
    step();
    $display("test_simul_release done");
  endtask

  task automatic test_nonowner();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1001;
    rel = 4'b1000;
    step();
    rel = '0;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL nonowner_rel gnt=%b required 0001", gnt);
    end
    step();
    checks++;
    if (gnt !== 4'b0001 || owner_id !== 2'd0) begin
      failures++;
      $display("FAIL nonowner_pending gnt=%b owner=%0d required 0001 0", gnt, owner_id);
    end
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL req_drop gnt=%b required 0000", gnt);
    end
    step(); step();
    checks++;
    if (gnt !== 4'b1000 || owner_id !== 2'd3) begin
      failures++;
      $display("FAIL pending_served gnt=%b owner=%0d required 1000 3", gnt, owner_id);
    end
    req = '0;
    step(); step(); step();
    $display("test_nonowner done");
  endtask

  task automatic test_sync();
    do_reset();
    gpio_i = 32'h1234_5678;
    step();
    checks++;
    if (gpio_sync_o !== 32'h0) begin
      failures++;
      $display("FAIL sync_lat1 sync=%h required 0", gpio_sync_o);
    end
    step();
    checks++;
    if (gpio_sync_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL sync_lat2 sync=%h required 12345678", gpio_sync_o);
    end
    $display("test_sync done");
  endtask

  task automatic test_async_reset();
    do_reset();
    req_out[2*GPIO +: GPIO] = 32'hDEAD_BEEF;
    req_oe = '1;
    gpio_i = 32'h0F0F_0F0F;
    req = 4'b0100;
    step(); step(); step();
    checks++;
    if (gnt !== 4'b0100 || gpio_oe_o !== 32'hFFFF_FFFF || gpio_sync_o !== 32'h0F0F_0F0F) begin
      failures++;
      $display("FAIL pre_reset gnt=%b oe=%h sync=%h required 0100 ffffffff 0f0f0f0f", gnt, gpio_oe_o, gpio_sync_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gpio_oe_o !== '0 || gpio_o !== '0 || gpio_sync_o !== '0 || owner_id !== 2'd3) begin
      failures++;
      $display("FAIL async_reset gnt=%b oe=%h o=%h sync=%h owner=%0d required 0 0 0 0 3", gnt, gpio_oe_o, gpio_o, gpio_sync_o, owner_id);
    end
    req = 4'b1111;
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001 || owner_id !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_tie gnt=%b owner=%0d required 0001 0", gnt, owner_id);
    end
    req = '0;
    step();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_simul_release();
    test_nonowner();
    test_sync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
